// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller.
//   - default parameter values (RAM depth, write/read hold times, park address)
//   - FSM state encoding
//   - completion record type
package mem_pkg;

  localparam int          DEF_DEPTH     = 32;
  localparam int          DEF_WR_CYCLES = 16;
  localparam int          DEF_RD_CYCLES = 2;
  localparam logic [31:0] DEF_PARK_ADDR = 32'h1000_0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Completion payload, held until the next completion overwrites it.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response handshake plus the RAM command bus.
//   slave  : controller side (takes requests, returns responses, drives RAM)
//   master : environment side (CPU issuing requests, RAM returning read data)
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_w_r;
  logic [31:0] ram_addr;
  logic [31:0] ram_wr_data;
  logic [31:0] ram_rd_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           ram_w_r, ram_addr, ram_wr_data
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           ram_w_r, ram_addr, ram_wr_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding CPU-to-RAM access controller.
// Accepts one request in IDLE, holds the RAM write command for WR_CYCLES or
// the read command for RD_CYCLES (capturing read data on the last edge),
// then pulses resp_valid for one cycle. Out-of-range addresses complete
// immediately with resp_err and never touch the RAM.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - mem_access_ctrl_if.slave: req_*, resp_*, ram_* signals
// Every output is a flop; the RAM bus value is derived from the next state
// so the command appears in the first cycle after acceptance.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int          DEPTH     = DEF_DEPTH,
  parameter int          WR_CYCLES = DEF_WR_CYCLES,
  parameter int          RD_CYCLES = DEF_RD_CYCLES,
  parameter logic [31:0] PARK_ADDR = DEF_PARK_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [7:0]  WR_CNT0 = 8'(WR_CYCLES - 1);
  localparam logic [7:0]  RD_CNT0 = 8'(RD_CYCLES - 1);

  logic [1:0]  state_q,       state_d;
  logic [7:0]  cnt_q,         cnt_d;
  logic [31:0] addr_q,        addr_d;
  logic [31:0] wdata_q,       wdata_d;
  resp_t       resp_q,        resp_d;
  logic        resp_valid_q,  resp_valid_d;
  logic        req_ready_q,   req_ready_d;
  logic        ram_w_r_q,     ram_w_r_d;
  logic [31:0] ram_addr_q,    ram_addr_d;
  logic [31:0] ram_wr_data_q, ram_wr_data_d;

  logic accept;
  // Gating on req_ready_q keeps the cycle right after reset release from
  // accepting while req_ready is still low.
  assign accept = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_d       = resp_q;
    resp_valid_d = 1'b0;
    req_ready_d  = req_ready_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          if (bus.req_addr < DEPTH_W) begin
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            state_d = bus.req_we ? ST_WRITE : ST_READ;
            cnt_d   = bus.req_we ? WR_CNT0 : RD_CNT0;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_d       = '{rdata: 32'h0, err: 1'b1};
          end
        end
      end
      ST_WRITE: begin
        if (cnt_q == 8'd0) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_d       = '{rdata: 32'h0, err: 1'b0};
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_READ: begin
        if (cnt_q == 8'd0) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_d       = '{rdata: bus.ram_rd_data, err: 1'b0};
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // RAM bus follows the state being entered; parked unless accessing.
    ram_w_r_d     = 1'b1;
    ram_addr_d    = PARK_ADDR;
    ram_wr_data_d = 32'h0;
    if (state_d == ST_WRITE) begin
      ram_w_r_d     = 1'b0;
      ram_addr_d    = addr_d;
      ram_wr_data_d = wdata_d;
    end else if (state_d == ST_READ) begin
      ram_addr_d    = addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      resp_q        <= '0;
      resp_valid_q  <= 1'b0;
      req_ready_q   <= 1'b0;
      ram_w_r_q     <= 1'b1;
      ram_addr_q    <= PARK_ADDR;
      ram_wr_data_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      resp_q        <= resp_d;
      resp_valid_q  <= resp_valid_d;
      req_ready_q   <= req_ready_d;
      ram_w_r_q     <= ram_w_r_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_q.rdata;
  assign bus.resp_err    = resp_q.err;
  assign bus.ram_w_r     = ram_w_r_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wr_data = ram_wr_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RAM model on the bus side, scoreboard of
// expected completions (data, error, latency) filled at acceptance and
// drained by a response monitor, plus per-scenario bus/handshake checks.
module tb_mem_access_ctrl;

  localparam int          WR   = 16;
  localparam int          RD   = 2;
  localparam logic [31:0] PARK = 32'h1000_0000;

  logic clk;
  logic rst;
  mem_access_ctrl_if bus();

  mem_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model
  logic [31:0] mem [0:31];
  always @(posedge clk) begin
    if (!bus.ram_w_r && bus.ram_addr < 32'd32)
      mem[bus.ram_addr[4:0]] <= bus.ram_wr_data;
  end
  assign bus.ram_rd_data = mem[bus.ram_addr[4:0]];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] shadow [0:31];
  bit          shadow_vld [0:31];
  int          total = 0;
  int          bad   = 0;
  bit          prev_rv = 0;

  task automatic sb_push(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    e.err   = (addr >= 32'd32);
    e.rdata = (we || e.err) ? 32'h0 : shadow[addr[4:0]];
    e.acc   = cyc;
    e.lat   = e.err ? 1 : (we ? WR + 1 : RD + 1);
    if (we && !e.err) begin
      shadow[addr[4:0]]     = wd;
      shadow_vld[addr[4:0]] = 1'b1;
    end
    sb.push_back(e);
  endtask

  // Waits (bounded) for req_ready, then presents one request for one edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_timeout: req_ready=%0b required 1", bus.req_ready);
      return;
    end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    sb_push(we, addr, wd);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(bus.req_ready && sb.size() == 0) && n < 60) begin @(negedge clk); n++; end
    if (!(bus.req_ready && sb.size() == 0)) begin
      total++; bad++;
      $display("FAIL idle_timeout: ready=%0b pending=%0d required ready=1 pending=0",
               bus.req_ready, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err,
         bus.ram_w_r, bus.ram_addr, bus.ram_wr_data} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1, PARK, 32'h0}) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%0b rv=%0b rd=%h err=%0b wr=%0b ad=%h wd=%h required 0 0 0 0 1 %h 0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err,
               bus.ram_w_r, bus.ram_addr, bus.ram_wr_data, PARK);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset: got %0b required 1", bus.req_ready);
    end
  endtask

  task automatic test_write();
    do_req(1'b1, 32'd1, 32'h1010_1010);
    for (int k = 1; k <= WR; k++) begin
      @(negedge clk);
      total++;
      if ({bus.ram_w_r, bus.ram_addr, bus.ram_wr_data, bus.resp_valid, bus.req_ready}
          !== {1'b0, 32'd1, 32'h1010_1010, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL write_window c%0d: wr=%0b ad=%h wd=%h rv=%0b rdy=%0b required 0 1 10101010 0 0",
                 k, bus.ram_w_r, bus.ram_addr, bus.ram_wr_data, bus.resp_valid, bus.req_ready);
      end
    end
    @(negedge clk);
    total++;
    if ({bus.resp_valid, bus.ram_w_r, bus.ram_addr} !== {1'b1, 1'b1, PARK}) begin
      bad++;
      $display("FAIL write_resp_cycle: rv=%0b wr=%0b ad=%h required 1 1 %h",
               bus.resp_valid, bus.ram_w_r, bus.ram_addr, PARK);
    end
    wait_idle();
    total++;
    if (mem[1] !== 32'h1010_1010) begin
      bad++; $display("FAIL ram_written: mem[1]=%h required 10101010", mem[1]);
    end
  endtask

  task automatic test_read_back();
    do_req(1'b1, 32'd31, 32'hFFFF_FFFF);
    wait_idle();
    do_req(1'b0, 32'd31, 32'h1234_5678);
    for (int k = 1; k <= RD; k++) begin
      @(negedge clk);
      total++;
      if ({bus.ram_w_r, bus.ram_addr, bus.ram_wr_data, bus.resp_valid} !== {1'b1, 32'd31, 32'h0, 1'b0}) begin
        bad++;
        $display("FAIL read_window c%0d: wr=%0b ad=%h wd=%h rv=%0b required 1 31 0 0",
                 k, bus.ram_w_r, bus.ram_addr, bus.ram_wr_data, bus.resp_valid);
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    total++;
    if ({bus.resp_rdata, bus.resp_err} !== {32'hFFFF_FFFF, 1'b0}) begin
      bad++;
      $display("FAIL resp_hold: rd=%h err=%0b required ffffffff 0", bus.resp_rdata, bus.resp_err);
    end
  endtask

  task automatic test_error();
    logic [31:0] addrs [2];
    addrs[0] = 32'd32; addrs[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      do_req(i == 1, addrs[i], 32'hCAFE_0000);
      @(negedge clk);
      total++;
      if ({bus.resp_valid, bus.ram_w_r, bus.ram_addr, bus.ram_wr_data, bus.req_ready}
          !== {1'b1, 1'b1, PARK, 32'h0, 1'b0}) begin
        bad++;
        $display("FAIL error_cycle a=%h: rv=%0b wr=%0b ad=%h wd=%h rdy=%0b required 1 1 %h 0 0",
                 addrs[i], bus.resp_valid, bus.ram_w_r, bus.ram_addr, bus.ram_wr_data, bus.req_ready, PARK);
      end
      @(negedge clk);
      total++;
      if ({bus.req_ready, bus.ram_addr} !== {1'b1, PARK}) begin
        bad++;
        $display("FAIL error_ready a=%h: rdy=%0b ad=%h required 1 %h", addrs[i], bus.req_ready, bus.ram_addr, PARK);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'd1; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    sb_push(1'b0, 32'd1, 32'h0);
    bus.req_addr = 32'd31;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.req_ready !== 1'b0 || (k <= RD && bus.ram_addr !== 32'd1)) begin
        bad++;
        $display("FAIL b2b_busy c%0d: rdy=%0b ad=%h required 0 and addr 1 in window",
                 k, bus.req_ready, bus.ram_addr);
      end
    end
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready: rdy=%0b required 1", bus.req_ready);
    end
    @(posedge clk); #1;
    sb_push(1'b0, 32'd31, 32'h0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.ram_w_r, bus.ram_addr} !== {1'b1, 32'd31}) begin
      bad++; $display("FAIL b2b_second_read: wr=%0b ad=%h required 1 31", bus.ram_w_r, bus.ram_addr);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_write();
    do_req(1'b1, 32'd5, 32'h5555_AAAA);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err,
         bus.ram_w_r, bus.ram_addr, bus.ram_wr_data} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1, PARK, 32'h0}) begin
      bad++;
      $display("FAIL midwrite_reset: rdy=%0b rv=%0b rd=%h err=%0b wr=%0b ad=%h wd=%h required 0 0 0 0 1 %h 0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err,
               bus.ram_w_r, bus.ram_addr, bus.ram_wr_data, PARK);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.ram_addr} !== {1'b1, 1'b0, PARK}) begin
      bad++;
      $display("FAIL midwrite_release: rdy=%0b rv=%0b ad=%h required 1 0 %h",
               bus.req_ready, bus.resp_valid, bus.ram_addr, PARK);
    end
    repeat (WR + 2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic        we;
      logic [31:0] a;
      a  = 32'($urandom_range(0, 33));
      we = 1'($urandom_range(0, 1));
      if (!we && a < 32 && !shadow_vld[a[4:0]]) we = 1'b1;
      do_req(we, a, $urandom);
      wait_idle();
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    rst = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (rst && bus.resp_valid) begin
          total++;
          if (prev_rv) begin
            bad++; $display("FAIL resp_pulse_width: resp_valid high two cycles, required one");
          end
          total++;
          if (sb.size() == 0) begin
            bad++; $display("FAIL spurious_resp: resp_valid=1 with nothing pending, required 0");
          end else begin
            exp_t e;
            int   l;
            e = sb.pop_front();
            l = cyc - e.acc + 1;
            if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err || l != e.lat) begin
              bad++;
              $display("FAIL resp_check: rd=%h err=%0b lat=%0d required rd=%h err=%0b lat=%0d",
                       bus.resp_rdata, bus.resp_err, l, e.rdata, e.err, e.lat);
            end
          end
        end
        prev_rv = rst && bus.resp_valid;
      end
    join_none

    test_reset();
    test_write();
    test_read_back();
    test_error();
    test_back_to_back();
    test_reset_mid_write();
    test_random();

    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain: %0d pending, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of valid RAM word addresses (0..DEPTH-1).
REQ-002 SHALL have parameter WR_CYCLES, default 16, cycles the RAM write command is held (1..255).
REQ-003 SHALL have parameter RD_CYCLES, default 2, cycles the RAM read command is held before data capture (1..255).
REQ-004 SHALL have parameter PARK_ADDR, default 32'h1000_0000, address driven to the RAM when no access is in progress.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid, input, 1 bit: CPU access request.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, 32 bits: word address.
REQ-010 SHALL have port req_wdata, input, 32 bits: write data.
REQ-011 SHALL have port req_ready, output, 1 bit: request accepted when req_valid && req_ready at a rising edge.
REQ-012 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata, output, 32 bits: read data, valid with resp_valid.
REQ-014 SHALL have port resp_err, output, 1 bit: out-of-range address, valid with resp_valid.
REQ-015 SHALL have port ram_w_r, output, 1 bit: to RAM, 1 = read, 0 = write.
REQ-016 SHALL have port ram_addr, output, 32 bits: to RAM.
REQ-017 SHALL have port ram_wr_data, output, 32 bits: to RAM.
REQ-018 SHALL have port ram_rd_data, input, 32 bits: from RAM.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, READ, RESP; all outputs registered.
REQ-020 SHALL assert req_ready only in IDLE; all request inputs are ignored in other states.
REQ-021 SHALL, on acceptance with req_addr < DEPTH, latch addr/wdata/we and enter WRITE (we=1) or READ (we=0), loading an 8-bit down-counter with WR_CYCLES-1 or RD_CYCLES-1.
REQ-022 SHALL, on acceptance with req_addr >= DEPTH, enter RESP directly with resp_err=1 and resp_rdata=0, without driving any RAM access.
REQ-023 SHALL, in WRITE, drive ram_w_r=0, ram_addr=latched addr, ram_wr_data=latched data for exactly WR_CYCLES cycles, then enter RESP.
REQ-024 SHALL, in READ, drive ram_w_r=1, ram_addr=latched addr, ram_wr_data=0 for exactly RD_CYCLES cycles and capture ram_rd_data at the final edge of that window into resp_rdata, then enter RESP.
REQ-025 SHALL, in RESP, pulse resp_valid for exactly one cycle, park the RAM bus, and return to IDLE.
REQ-026 SHALL park the RAM bus (ram_w_r=1, ram_addr=PARK_ADDR, ram_wr_data=0) in IDLE and RESP.
REQ-027 SHALL hold resp_rdata and resp_err stable after resp_valid until the next completion; resp_rdata=0 for writes.
REQ-028 SHALL yield latency acceptance edge to resp_valid high of WR_CYCLES+1 cycles (write), RD_CYCLES+1 (read), 1 (error); minimum spacing between acceptances is latency+1 cycles.
REQ-029 SHALL compare req_addr against DEPTH as unsigned 32-bit; address DEPTH-1 is valid, DEPTH is error.

Reset
REQ-030 SHALL, on rst low at any time including mid-access, immediately enter IDLE, clear counter and latched request, and drive req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, ram_w_r=1, ram_addr=PARK_ADDR, ram_wr_data=0.
REQ-031 SHALL assert req_ready in the first cycle after rst deasserts; an aborted access produces no resp_valid.

Structure
REQ-032 SHALL place the FSM state encoding and default parameter values (DEPTH, WR_CYCLES, RD_CYCLES, PARK_ADDR) in a shared package mem_pkg.
REQ-033 SHALL be a single module with no sub-modules; cycle counter inline.

Verification
REQ-034 Write addr 1 data 32'h10101010 -> ram_w_r=0, ram_addr=1 for 16 cycles, resp_valid at 17th cycle after acceptance, resp_err=0.
REQ-035 Write addr 31 data 32'hFFFFFFFF, then read addr 31 -> read window 2 cycles, resp_rdata=32'hFFFFFFFF at RD_CYCLES+1 cycles after acceptance.
REQ-036 Read addr 32 -> no RAM access (bus stays parked at 32'h1000_0000), resp_valid next cycle with resp_err=1, resp_rdata=0.
REQ-037 req_valid held high continuously for two reads (addrs 1, 31) -> second accepted only in IDLE after RESP; each resp_valid exactly one cycle.
REQ-038 rst low during cycle 5 of a write -> outputs at reset values immediately, no resp_valid, req_ready=1 first cycle after release.
